rob_commit_ctrl: RTL and testbench

In-order retirement sequencer for the tagged register file. It hands reorder tags to the decoder, collects execution results by tag, and retires the oldest finished entry each cycle onto the register file commit port. A mispredicted branch/jalr retires its link value and raises a one-cycle flush that clears every busy/reorder tag downstream.

---
 rtl/rob_commit_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_rob_commit_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_ctrl.sv
// In-order retirement sequencer: grants reorder tags, collects results by tag and
// retires the oldest finished entry per cycle; a mispredicted retire flushes everything.
module rob_commit_ctrl #(
  parameter int ROB_AW    = 4,
  parameter int ROB_DEPTH = 16,
  parameter int REG_AW    = 5,
  parameter int DATA_W    = 32
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_rdy,
  input  logic              in_alloc_valid,
  input  logic [REG_AW-1:0] in_alloc_rd,
  output logic [ROB_AW-1:0] out_alloc_tag,
  output logic              out_full,
  input  logic              in_wb_valid,
  input  logic [ROB_AW-1:0] in_wb_tag,
  input  logic [DATA_W-1:0] in_wb_value,
  input  logic              in_wb_mispredict,
  input  logic [DATA_W-1:0] in_wb_target,
  output logic              out_commit_enable,
  output logic [REG_AW-1:0] out_commit_rd,
  output logic [DATA_W-1:0] out_commit_value,
  output logic [ROB_AW-1:0] out_commit_tag,
  output logic              out_flush_enable,
  output logic [DATA_W-1:0] out_flush_pc
);

  typedef enum logic [1:0] {S_EMPTY, S_RUN, S_FLUSH} state_t;

  // Tag 0 means "no tag", so pointers cycle through 1..ROB_DEPTH-1 only.
  function automatic logic [ROB_AW-1:0] next_tag(input logic [ROB_AW-1:0] t);
    next_tag = (t == ROB_AW'(ROB_DEPTH - 1)) ? ROB_AW'(1) : t + ROB_AW'(1);
  endfunction

  state_t              state_q, state_d;
  logic [ROB_AW-1:0]   head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic [ROB_DEPTH-1:0] valid_q, valid_d, ready_q, ready_d, misp_q, misp_d;
  logic [REG_AW-1:0]   rd_q     [ROB_DEPTH];
  logic [REG_AW-1:0]   rd_d     [ROB_DEPTH];
  logic [DATA_W-1:0]   value_q  [ROB_DEPTH];
  logic [DATA_W-1:0]   value_d  [ROB_DEPTH];
  logic [DATA_W-1:0]   target_q [ROB_DEPTH];
  logic [DATA_W-1:0]   target_d [ROB_DEPTH];

  logic                commit_en_q, commit_en_d;
  logic [REG_AW-1:0]   commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0]   commit_value_q, commit_value_d;
  logic [ROB_AW-1:0]   commit_tag_q, commit_tag_d;
  logic                flush_en_q, flush_en_d;
  logic [DATA_W-1:0]   flush_pc_q, flush_pc_d;

  logic alloc_ok, wb_ok, retire, retire_misp;

  always_comb begin
    state_d        = state_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    valid_d        = valid_q;
    ready_d        = ready_q;
    misp_d         = misp_q;
    rd_d           = rd_q;
    value_d        = value_q;
    target_d       = target_q;
    commit_en_d    = 1'b0;
    commit_rd_d    = '0;
    commit_value_d = '0;
    commit_tag_d   = '0;
    flush_en_d     = 1'b0;
    flush_pc_d     = '0;

    alloc_ok    = in_alloc_valid && !out_full && (state_q != S_FLUSH);
    wb_ok       = in_wb_valid && (in_wb_tag != '0) && valid_q[in_wb_tag] && (state_q != S_FLUSH);
    retire      = (state_q == S_RUN) && valid_q[head_q] && ready_q[head_q];
    retire_misp = retire && misp_q[head_q];

    if (wb_ok) begin
      value_d[in_wb_tag]  = in_wb_value;
      misp_d[in_wb_tag]   = in_wb_mispredict;
      target_d[in_wb_tag] = in_wb_target;
      ready_d[in_wb_tag]  = 1'b1;
    end

    if (retire) begin
      commit_en_d     = 1'b1;
      commit_rd_d     = rd_q[head_q];
      commit_value_d  = value_q[head_q];
      commit_tag_d    = head_q;
      valid_d[head_q] = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = next_tag(head_q);
    end

    if (alloc_ok) begin
      valid_d[tail_q] = 1'b1;
      ready_d[tail_q] = 1'b0;
      rd_d[tail_q]    = in_alloc_rd;
      tail_d          = next_tag(tail_q);
    end

    case ({alloc_ok, retire})
      2'b10:   count_d = count_q + ROB_AW'(1);
      2'b01:   count_d = count_q - ROB_AW'(1);
      default: count_d = count_q;
    endcase

    if (retire_misp) begin
      flush_en_d = 1'b1;
      flush_pc_d = target_q[head_q];
    end

    // Wrong-path entries are dropped at the retire edge and kept clear through S_FLUSH.
    if (retire_misp || (state_q == S_FLUSH)) begin
      valid_d = '0;
      ready_d = '0;
      head_d  = ROB_AW'(1);
      tail_d  = ROB_AW'(1);
      count_d = '0;
    end

    case (state_q)
      S_EMPTY: if (alloc_ok) state_d = S_RUN;
      S_RUN: begin
        if (retire_misp)         state_d = S_FLUSH;
        else if (count_d == '0)  state_d = S_EMPTY;
      end
      S_FLUSH: state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      state_q        <= S_EMPTY;
      head_q         <= ROB_AW'(1);
      tail_q         <= ROB_AW'(1);
      count_q        <= '0;
      valid_q        <= '0;
      ready_q        <= '0;
      misp_q         <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rd_q[i]     <= '0;
        value_q[i]  <= '0;
        target_q[i] <= '0;
      end
      commit_en_q    <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_tag_q   <= '0;
      flush_en_q     <= 1'b0;
      flush_pc_q     <= '0;
    end else if (in_rdy) begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      ready_q        <= ready_d;
      misp_q         <= misp_d;
      rd_q           <= rd_d;
      value_q        <= value_d;
      target_q       <= target_d;
      commit_en_q    <= commit_en_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      commit_tag_q   <= commit_tag_d;
      flush_en_q     <= flush_en_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  assign out_alloc_tag     = tail_q;
  assign out_full          = (count_q == ROB_AW'(ROB_DEPTH - 1));
  assign out_commit_enable = commit_en_q;
  assign out_commit_rd     = commit_rd_q;
  assign out_commit_value  = commit_value_q;
  assign out_commit_tag    = commit_tag_q;
  assign out_flush_enable  = flush_en_q;
  assign out_flush_pc      = flush_pc_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Scoreboard bench for rob_commit_ctrl: stimulus pushes expected retirements,
// a negedge monitor pops and compares each commit pulse as it is consumed.
module tb_rob_commit_ctrl;
  localparam int ROB_AW = 4, ROB_DEPTH = 16, REG_AW = 5, DATA_W = 32;

  logic              in_clk = 1'b0;
  logic              in_rst = 1'b0;
  logic              in_rdy = 1'b1;
  logic              in_alloc_valid = 1'b0;
  logic [REG_AW-1:0] in_alloc_rd = '0;
  logic              in_wb_valid = 1'b0;
  logic [ROB_AW-1:0] in_wb_tag = '0;
  logic [DATA_W-1:0] in_wb_value = '0;
  logic              in_wb_mispredict = 1'b0;
  logic [DATA_W-1:0] in_wb_target = '0;
  logic [ROB_AW-1:0] out_alloc_tag;
  logic              out_full;
  logic              out_commit_enable;
  logic [REG_AW-1:0] out_commit_rd;
  logic [DATA_W-1:0] out_commit_value;
  logic [ROB_AW-1:0] out_commit_tag;
  logic              out_flush_enable;
  logic [DATA_W-1:0] out_flush_pc;

  rob_commit_ctrl #(.ROB_AW(ROB_AW), .ROB_DEPTH(ROB_DEPTH), .REG_AW(REG_AW), .DATA_W(DATA_W)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_rdy(in_rdy),
    .in_alloc_valid(in_alloc_valid), .in_alloc_rd(in_alloc_rd),
    .out_alloc_tag(out_alloc_tag), .out_full(out_full),
    .in_wb_valid(in_wb_valid), .in_wb_tag(in_wb_tag), .in_wb_value(in_wb_value),
    .in_wb_mispredict(in_wb_mispredict), .in_wb_target(in_wb_target),
    .out_commit_enable(out_commit_enable), .out_commit_rd(out_commit_rd),
    .out_commit_value(out_commit_value), .out_commit_tag(out_commit_tag),
    .out_flush_enable(out_flush_enable), .out_flush_pc(out_flush_pc)
  );

  always #5 in_clk = ~in_clk;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] value;
    logic [ROB_AW-1:0] tag;
    logic              flush;
    logic [DATA_W-1:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a pulse is consumed at the next edge only when in_rdy is high.
  always @(negedge in_clk) begin
    exp_t e;
    if (out_commit_enable === 1'b1 && in_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got tag %0d value 0x%0h, required no commit",
                 out_commit_tag, out_commit_value);
      end else begin
        e = exp_q.pop_front();
        $display("commit tag=%0d rd=%0d value=0x%0h flush=%0b pc=0x%0h",
                 out_commit_tag, out_commit_rd, out_commit_value, out_flush_enable, out_flush_pc);
        chk("commit_tag",   32'(out_commit_tag),   32'(e.tag));
        chk("commit_rd",    32'(out_commit_rd),    32'(e.rd));
        chk("commit_value", out_commit_value,      e.value);
        chk("flush_enable", 32'(out_flush_enable), 32'(e.flush));
        chk("flush_pc",     out_flush_pc,          e.pc);
      end
    end else if (out_flush_enable === 1'b1 && in_rdy === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL lone_flush: got flush pc 0x%0h without commit, required none", out_flush_pc);
    end
  end

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_reset();
    in_rst = 1'b0;
    in_rdy = 1'b1;
    in_alloc_valid = 1'b0;
    in_wb_valid = 1'b0;
    in_wb_mispredict = 1'b0;
    tick();
    in_rst = 1'b1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_alloc_tag"},    32'(out_alloc_tag),     1);
    chk({pfx, "_full"},         32'(out_full),          0);
    chk({pfx, "_commit_en"},    32'(out_commit_enable), 0);
    chk({pfx, "_commit_rd"},    32'(out_commit_rd),     0);
    chk({pfx, "_commit_value"}, out_commit_value,       0);
    chk({pfx, "_commit_tag"},   32'(out_commit_tag),    0);
    chk({pfx, "_flush_en"},     32'(out_flush_enable),  0);
    chk({pfx, "_flush_pc"},     out_flush_pc,           0);
  endtask

  task automatic alloc(input logic [REG_AW-1:0] rd, input logic [ROB_AW-1:0] exp_tag);
    chk("alloc_tag", 32'(out_alloc_tag), 32'(exp_tag));
    chk("alloc_not_full", 32'(out_full), 0);
    in_alloc_valid = 1'b1;
    in_alloc_rd = rd;
    tick();
    in_alloc_valid = 1'b0;
  endtask

  task automatic wb(input logic [ROB_AW-1:0] tag, input logic [DATA_W-1:0] val,
                    input logic misp, input logic [DATA_W-1:0] tgt);
    in_wb_valid = 1'b1;
    in_wb_tag = tag;
    in_wb_value = val;
    in_wb_mispredict = misp;
    in_wb_target = tgt;
    tick();
    in_wb_valid = 1'b0;
    in_wb_mispredict = 1'b0;
  endtask

  task automatic push(input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] val,
                      input logic [ROB_AW-1:0] tag, input logic fl, input logic [DATA_W-1:0] pc);
    exp_t e;
    e.rd = rd; e.value = val; e.tag = tag; e.flush = fl; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: single allocate / writeback / retire
    do_reset();
    check_reset_outputs("t1_reset");
    alloc(5'd5, 4'd1);
    push(5'd5, 32'h1234, 4'd1, 1'b0, 32'h0);
    wb(4'd1, 32'h1234, 1'b0, 32'h0);
    chk("t1_no_early_commit", 32'(out_commit_enable), 0);
    tick();
    chk("t1_commit_latency", 32'(out_commit_enable), 1);
    drain("t1");
    chk("t1_commit_dropped", 32'(out_commit_enable), 0);
    chk("t1_tail", 32'(out_alloc_tag), 2);
    chk("t1_full", 32'(out_full), 0);

    // 2: out-of-order writebacks retire in tag order
    do_reset();
    alloc(5'd10, 4'd1);
    alloc(5'd11, 4'd2);
    alloc(5'd12, 4'd3);
    wb(4'd3, 32'h33, 1'b0, 32'h0);
    push(5'd10, 32'h11, 4'd1, 1'b0, 32'h0);
    wb(4'd1, 32'h11, 1'b0, 32'h0);
    push(5'd11, 32'h22, 4'd2, 1'b0, 32'h0);
    push(5'd12, 32'h33, 4'd3, 1'b0, 32'h0);
    wb(4'd2, 32'h22, 1'b0, 32'h0);
    drain("t2");

    // 3: fill to capacity, refuse, retire one, wrap the tail
    do_reset();
    for (int i = 1; i < ROB_DEPTH; i++) alloc(REG_AW'(i), ROB_AW'(i));
    chk("t3_full", 32'(out_full), 1);
    chk("t3_tail_wrapped", 32'(out_alloc_tag), 1);
    in_alloc_valid = 1'b1;
    in_alloc_rd = 5'd31;
    tick();
    in_alloc_valid = 1'b0;
    chk("t3_refused_tail", 32'(out_alloc_tag), 1);
    chk("t3_still_full", 32'(out_full), 1);
    push(5'd1, 32'hA1, 4'd1, 1'b0, 32'h0);
    wb(4'd1, 32'hA1, 1'b0, 32'h0);
    in_alloc_valid = 1'b1;
    in_alloc_rd = 5'd30;
    tick();
    in_alloc_valid = 1'b0;
    chk("t3_same_cycle_refused", 32'(out_alloc_tag), 1);
    chk("t3_full_relieved", 32'(out_full), 0);
    chk("t3_commit_seen", 32'(out_commit_enable), 1);
    alloc(5'd20, 4'd1);
    chk("t3_tail_after_wrap", 32'(out_alloc_tag), 2);
    chk("t3_full_again", 32'(out_full), 1);
    drain("t3");

    // 4: mispredicted retire flushes the younger entry
    do_reset();
    alloc(5'd1, 4'd1);
    alloc(5'd7, 4'd2);
    push(5'd1, 32'h44, 4'd1, 1'b1, 32'h80);
    wb(4'd1, 32'h44, 1'b1, 32'h80);
    wb(4'd2, 32'h77, 1'b0, 32'h0);
    chk("t4_commit_en", 32'(out_commit_enable), 1);
    chk("t4_flush_en", 32'(out_flush_enable), 1);
    chk("t4_flush_pc", out_flush_pc, 32'h80);
    chk("t4_tail_reset", 32'(out_alloc_tag), 1);
    in_alloc_valid = 1'b1;
    in_alloc_rd = 5'd9;
    tick();
    in_alloc_valid = 1'b0;
    chk("t4_flush_dropped", 32'(out_flush_enable), 0);
    chk("t4_commit_dropped", 32'(out_commit_enable), 0);
    chk("t4_alloc_ignored", 32'(out_alloc_tag), 1);
    repeat (3) tick();
    chk("t4_tail_idle", 32'(out_alloc_tag), 1);
    alloc(5'd3, 4'd1);
    push(5'd3, 32'h55, 4'd1, 1'b0, 32'h0);
    wb(4'd1, 32'h55, 1'b0, 32'h0);
    drain("t4");

    // 5: freeze holds a pending pulse, which is consumed exactly once
    do_reset();
    alloc(5'd4, 4'd1);
    push(5'd4, 32'hBEEF, 4'd1, 1'b0, 32'h0);
    wb(4'd1, 32'hBEEF, 1'b0, 32'h0);
    tick();
    in_rdy = 1'b0;
    in_alloc_valid = 1'b1;
    in_alloc_rd = 5'd2;
    repeat (3) begin
      tick();
      chk("t5_frozen_commit_en", 32'(out_commit_enable), 1);
      chk("t5_frozen_value", out_commit_value, 32'hBEEF);
      chk("t5_frozen_tag", 32'(out_commit_tag), 1);
      chk("t5_frozen_alloc_tag", 32'(out_alloc_tag), 2);
    end
    in_alloc_valid = 1'b0;
    in_rdy = 1'b1;
    tick();
    chk("t5_pulse_consumed", 32'(out_commit_enable), 0);
    chk("t5_tail", 32'(out_alloc_tag), 2);
    drain("t5");

    // 6: ignored writebacks, then reset during S_FLUSH
    do_reset();
    wb(4'd0, 32'h1, 1'b0, 32'h0);
    wb(4'd9, 32'h2, 1'b0, 32'h0);
    repeat (2) tick();
    chk("t6_no_commit", 32'(out_commit_enable), 0);
    chk("t6_tail", 32'(out_alloc_tag), 1);
    chk("t6_full", 32'(out_full), 0);
    alloc(5'd6, 4'd1);
    alloc(5'd8, 4'd2);
    push(5'd6, 32'h9, 4'd1, 1'b1, 32'h100);
    wb(4'd1, 32'h9, 1'b1, 32'h100);
    tick();
    chk("t6_flush_en", 32'(out_flush_enable), 1);
    in_rst = 1'b0;
    tick();
    in_rst = 1'b1;
    check_reset_outputs("t6_reset");
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
